// File: rtl/store_buffer.sv
// Write-back store buffer in front of the data memory: queues stores, drains one per
// idle cycle, forwards loads from the youngest matching entry, otherwise reads memory.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_ready,
    output logic                       ld_rsp_valid,
    output logic [DW-1:0]              ld_rsp_data,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic                       mem_wrt,
    output logic                       mem_read,
    input  logic [DW-1:0]              mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0] sb_count,
    output logic                       sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LD_ISSUE = 2'd1;
    localparam logic [1:0] S_LD_WAIT  = 2'd2;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_wrt_q, mem_wrt_d;
    logic          mem_read_q, mem_read_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic          full;
    logic          push;
    logic          ld_acc;
    logic          pop;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;

    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;
    assign ld_ready = (state_q == S_IDLE) && !full;
    assign push     = st_valid && !full;
    assign ld_acc   = ld_valid && ld_ready;
    assign pop      = (state_q == S_IDLE) && !ld_acc && (count_q != '0);

    // Walk entries oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wrt_d   = 1'b0;
        mem_read_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (ld_acc) begin
                    if (hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = hit_data;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = ld_addr;
                        state_d    = S_LD_ISSUE;
                    end
                end else if (pop) begin
                    mem_wrt_d   = 1'b1;
                    mem_addr_d  = addr_q[rd_ptr_q];
                    mem_wdata_d = data_q[rd_ptr_q];
                end
            end
            S_LD_ISSUE: state_d = S_LD_WAIT;
            S_LD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign count_d  = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wrt_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wrt_q   <= mem_wrt_d;
            mem_read_q  <= mem_read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Entry storage needs no reset: occupancy is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

    assign ld_rsp_valid = rsp_valid_q;
    assign ld_rsp_data  = rsp_data_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wrt      = mem_wrt_q;
    assign mem_read     = mem_read_q;
    assign sb_count     = count_q;
    assign sb_empty     = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a DEPTH=4 and a DEPTH=2 instance share stimulus, each
// checked every cycle against a list-based model of the buffer and its data memory.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b0;
    logic        st_valid = 1'b0;
    logic [15:0] st_addr = '0;
    logic [15:0] st_data = '0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_addr = '0;

    always #5 clk = ~clk;

    logic        st_ready0, ld_ready0, rv0, mw0, mr0, emp0;
    logic [15:0] rd0, ma0, mwd0, mrd0;
    logic [2:0]  cnt0;
    logic        st_ready1, ld_ready1, rv1, mw1, mr1, emp1;
    logic [15:0] rd1, ma1, mwd1, mrd1;
    logic [1:0]  cnt1;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) u_sb4 (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready0),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready0),
        .ld_rsp_valid(rv0), .ld_rsp_data(rd0),
        .mem_addr(ma0), .mem_wdata(mwd0), .mem_wrt(mw0), .mem_read(mr0), .mem_rdata(mrd0),
        .sb_count(cnt0), .sb_empty(emp0)
    );

    store_buffer #(.DEPTH(2), .AW(16), .DW(16)) u_sb2 (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready1),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready1),
        .ld_rsp_valid(rv1), .ld_rsp_data(rd1),
        .mem_addr(ma1), .mem_wdata(mwd1), .mem_wrt(mw1), .mem_read(mr1), .mem_rdata(mrd1),
        .sb_count(cnt1), .sb_empty(emp1)
    );

    function automatic logic [15:0] seed(input int i);
        return (i == 6) ? 16'hDEAD : 16'(i * 16'h0111 + 16'h00A5);
    endfunction

    logic [15:0] tmem0 [16];
    logic [15:0] tmem1 [16];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) tmem0[i] <= seed(i);
        end else begin
            if (mw0) tmem0[ma0[3:0]] <= mwd0;
            if (mr0) mrd0 <= tmem0[ma0[3:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) tmem1[i] <= seed(i);
        end else begin
            if (mw1) tmem1[ma1[3:0]] <= mwd1;
            if (mr1) mrd1 <= tmem1[ma1[3:0]];
        end
    end

    logic [31:0] o_sr [2], o_lr [2], o_rv [2], o_rd [2], o_ma [2];
    logic [31:0] o_mwd [2], o_mw [2], o_mr [2], o_cnt [2], o_emp [2];
    assign o_sr[0]  = 32'(st_ready0);  assign o_sr[1]  = 32'(st_ready1);
    assign o_lr[0]  = 32'(ld_ready0);  assign o_lr[1]  = 32'(ld_ready1);
    assign o_rv[0]  = 32'(rv0);        assign o_rv[1]  = 32'(rv1);
    assign o_rd[0]  = 32'(rd0);        assign o_rd[1]  = 32'(rd1);
    assign o_ma[0]  = 32'(ma0);        assign o_ma[1]  = 32'(ma1);
    assign o_mwd[0] = 32'(mwd0);       assign o_mwd[1] = 32'(mwd1);
    assign o_mw[0]  = 32'(mw0);        assign o_mw[1]  = 32'(mw1);
    assign o_mr[0]  = 32'(mr0);        assign o_mr[1]  = 32'(mr1);
    assign o_cnt[0] = 32'(cnt0);       assign o_cnt[1] = 32'(cnt1);
    assign o_emp[0] = 32'(emp0);       assign o_emp[1] = 32'(emp1);

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: per instance an oldest-first list of stores, a load countdown and a memory image.
    int          msz   [2];
    logic [15:0] mqa   [2][8];
    logic [15:0] mqd   [2][8];
    int          mbusy [2];
    logic [15:0] mpend [2];
    logic [15:0] mmem  [2][16];
    logic        e_rv  [2];
    logic [15:0] e_rd  [2];
    logic        e_mw  [2];
    logic        e_mr  [2];
    logic [15:0] e_ma  [2];
    logic [15:0] e_mwd [2];

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic model_reset(input int i);
        msz[i] = 0; mbusy[i] = 0; mpend[i] = '0;
        e_rv[i] = 0; e_rd[i] = '0; e_mw[i] = 0; e_mr[i] = 0; e_ma[i] = '0; e_mwd[i] = '0;
    endtask

    task automatic model_step(input int i, input bit sv, input logic [15:0] sa, input logic [15:0] sd,
                              input bit lv, input logic [15:0] la);
        bit          push, lacc, hit;
        logic [15:0] hd;
        if (e_mw[i]) mmem[i][e_ma[i][3:0]] = e_mwd[i];
        push = sv && (msz[i] != dep(i));
        lacc = lv && (mbusy[i] == 0) && (msz[i] != dep(i));
        e_mw[i] = 0; e_mr[i] = 0; e_rv[i] = 0;
        if (mbusy[i] == 0) begin
            if (lacc) begin
                hit = 0; hd = '0;
                for (int k = 0; k < msz[i]; k++)
                    if (mqa[i][k] == la) begin hit = 1; hd = mqd[i][k]; end
                if (hit) begin
                    e_rv[i] = 1; e_rd[i] = hd;
                end else begin
                    e_mr[i] = 1; e_ma[i] = la; mbusy[i] = 2; mpend[i] = la;
                end
            end else if (msz[i] > 0) begin
                e_mw[i] = 1; e_ma[i] = mqa[i][0]; e_mwd[i] = mqd[i][0];
                for (int k = 0; k < 7; k++) begin mqa[i][k] = mqa[i][k+1]; mqd[i][k] = mqd[i][k+1]; end
                msz[i]--;
            end
        end else if (mbusy[i] == 2) begin
            mbusy[i] = 1;
        end else begin
            e_rv[i] = 1; e_rd[i] = mmem[i][mpend[i][3:0]]; mbusy[i] = 0;
        end
        if (push) begin
            mqa[i][msz[i]] = sa; mqd[i][msz[i]] = sd; msz[i]++;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("d%0d st_ready", dep(i)), o_sr[i], 32'(msz[i] != dep(i)));
            chk_eq($sformatf("d%0d ld_ready", dep(i)), o_lr[i], 32'((mbusy[i] == 0) && (msz[i] != dep(i))));
            chk_eq($sformatf("d%0d ld_rsp_valid", dep(i)), o_rv[i], 32'(e_rv[i]));
            chk_eq($sformatf("d%0d ld_rsp_data", dep(i)), o_rd[i], 32'(e_rd[i]));
            chk_eq($sformatf("d%0d mem_wrt", dep(i)), o_mw[i], 32'(e_mw[i]));
            chk_eq($sformatf("d%0d mem_read", dep(i)), o_mr[i], 32'(e_mr[i]));
            chk_eq($sformatf("d%0d mem_addr", dep(i)), o_ma[i], 32'(e_ma[i]));
            chk_eq($sformatf("d%0d mem_wdata", dep(i)), o_mwd[i], 32'(e_mwd[i]));
            chk_eq($sformatf("d%0d sb_count", dep(i)), o_cnt[i], 32'(msz[i]));
            chk_eq($sformatf("d%0d sb_empty", dep(i)), o_emp[i], 32'(msz[i] == 0));
        end
    endtask

    task automatic step(input bit sv, input logic [15:0] sa, input logic [15:0] sd,
                        input bit lv, input logic [15:0] la);
        @(negedge clk);
        check_outputs();
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        model_step(0, sv, sa, sd, lv, la);
        model_step(1, sv, sa, sd, lv, la);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(0, '0, '0, 0, '0);
    endtask

    // Asynchronous reset asserted in the middle of the low clock phase.
    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        st_valid = 0; ld_valid = 0;
        #2 rst = 1'b0;
        #1;
        model_reset(0); model_reset(1);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            for (int a = 0; a < 16; a++) mmem[i][a] = seed(a);
        end
        #1 rst = 1'b0;
        mem_init = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs();
        mem_init = 1'b0;
        rst = 1'b1;

        // two drains, back to back, in store order
        step(1, 16'h0004, 16'h1234, 0, '0);
        step(1, 16'h0006, 16'hDEAD, 0, '0);
        idle(4);

        // forwarding picks the younger of two same-address stores
        step(1, 16'h0002, 16'h1111, 0, '0);
        step(1, 16'h0002, 16'h2222, 0, '0);
        step(0, '0, '0, 1, 16'h0002);
        idle(4);

        // miss from an empty buffer reads memory[6]
        step(0, '0, '0, 1, 16'h0006);
        idle(5);

        // stores pile up behind a miss; the small instance fills and refuses
        step(1, 16'h0008, 16'hAAAA, 1, 16'h000E);
        step(1, 16'h000A, 16'hBBBB, 0, '0);
        step(1, 16'h000C, 16'hCCCC, 0, '0);
        step(1, 16'h000C, 16'hCCCC, 0, '0);
        step(1, 16'h000C, 16'hCCCC, 0, '0);
        idle(8);

        // reset while waiting for read data with two stores queued
        step(1, 16'h0008, 16'h5555, 1, 16'h000E);
        step(1, 16'h000A, 16'h6666, 0, '0);
        do_reset();
        idle(6);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7) * 2), 16'($urandom),
                     ($urandom_range(0, 9) < 3), 16'($urandom_range(0, 7) * 2));
            end
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
